// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline stages, the shared memory bus
// and the stall controls. master = arbiter view, slave = pipeline/bus view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_valid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_be;
  logic                  dm_valid;
  logic [DATA_W-1:0]     dm_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  PCwrite;
  logic                  IF_IDwrite;
  logic                  mem_stall;
  logic                  timeout_err;

  modport master (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_valid, if_rdata, dm_valid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output PCwrite, IF_IDwrite, mem_stall, timeout_err
  );

  modport slave (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_valid, if_rdata, dm_valid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  PCwrite, IF_IDwrite, mem_stall, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access,
// one transaction at a time, with bus timeout and pipeline stall generation.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT_ACC, WAIT_RESP} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                terr_q, terr_d;

  logic                rsp_done;
  logic                tmo_hit;
  logic                xfer_end;
  logic                if_done;
  logic                dm_done;

  // A real response on the timeout cycle wins over the abort.
  assign rsp_done = (state_q == WAIT_RESP) && bus.mem_rvalid;
  assign tmo_hit  = (state_q != IDLE) && (cnt_q == CNT_MAX) && !rsp_done;
  assign xfer_end = rsp_done || tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  // Data requests win a tie: they belong to the older instruction.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q | tmo_hit;
    case (state_q)
      IDLE: begin
        if (bus.dm_req) begin
          owner_d = OWN_DM;
          addr_d  = bus.dm_addr;
          we_d    = bus.dm_we;
          wdata_d = bus.dm_wdata;
          be_d    = bus.dm_be;
          cnt_d   = '0;
          state_d = WAIT_ACC;
        end else if (bus.if_req) begin
          owner_d = OWN_IF;
          addr_d  = bus.if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          be_d    = '1;
          cnt_d   = '0;
          state_d = WAIT_ACC;
        end
      end
      WAIT_ACC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tmo_hit)            state_d = IDLE;
        else if (bus.mem_ready) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (xfer_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_done         = xfer_end && (owner_q == OWN_IF);
    dm_done         = xfer_end && (owner_q == OWN_DM);
    bus.mem_req     = (state_q == WAIT_ACC);
    bus.mem_we      = (state_q == WAIT_ACC) && we_q;
    bus.mem_addr    = addr_q;
    bus.mem_wdata   = wdata_q;
    bus.mem_be      = be_q;
    bus.if_valid    = if_done;
    bus.dm_valid    = dm_done;
    bus.if_rdata    = (rsp_done && owner_q == OWN_IF) ? bus.mem_rdata : '0;
    bus.dm_rdata    = (rsp_done && owner_q == OWN_DM) ? bus.mem_rdata : '0;
    bus.mem_stall   = bus.dm_req && !dm_done;
    bus.PCwrite     = !((bus.if_req && !if_done) || (bus.dm_req && !dm_done));
    bus.IF_IDwrite  = bus.PCwrite;
    bus.timeout_err = terr_q;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: drives the pipeline and bus sides cycle
// by cycle and scores every valid pulse against a queue of expected responses.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 15;

  typedef struct {
    logic        is_dm;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.dm_req     = 1'b0;
    bus.dm_we      = 1'b0;
    bus.dm_addr    = '0;
    bus.dm_wdata   = '0;
    bus.dm_be      = 4'hF;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_req: got %b want 0", bus.mem_req); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_we: got %b want 0", bus.mem_we); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_terr: got %b want 0", bus.timeout_err); end
    total++; if ({bus.if_valid, bus.dm_valid} !== 2'b00) begin bad++; $display("[TB] FAIL rst_valids: got %b%b want 00", bus.if_valid, bus.dm_valid); end
    total++; if ({bus.PCwrite, bus.IF_IDwrite, bus.mem_stall} !== 3'b110) begin bad++; $display("[TB] FAIL rst_stalls: got %b%b%b want 110", bus.PCwrite, bus.IF_IDwrite, bus.mem_stall); end
    bus.if_req = 1'b1;
    #1;
    total++; if (bus.PCwrite !== 1'b0) begin bad++; $display("[TB] FAIL rst_pending_pcw: got %b want 0", bus.PCwrite); end
    bus.if_req = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] data, input string name);
    cyc();
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("[TB] FAIL %s_c0_mem_req: got %b want 0", name, bus.mem_req); end
    total++; if ({bus.PCwrite, bus.IF_IDwrite} !== 2'b00) begin bad++; $display("[TB] FAIL %s_c0_pcw: got %b%b want 00", name, bus.PCwrite, bus.IF_IDwrite); end
    cyc();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("[TB] FAIL %s_c1_mem_req: got %b want 1", name, bus.mem_req); end
    total++; if (bus.mem_addr !== addr) begin bad++; $display("[TB] FAIL %s_c1_addr: got %h want %h", name, bus.mem_addr, addr); end
    total++; if ({bus.mem_we, bus.mem_be} !== 5'b0_1111) begin bad++; $display("[TB] FAIL %s_c1_we_be: got %b %b want 0 1111", name, bus.mem_we, bus.mem_be); end
    total++; if (bus.PCwrite !== 1'b0) begin bad++; $display("[TB] FAIL %s_c1_pcw: got %b want 0", name, bus.PCwrite); end
    cyc();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = data;
    exp_q.push_back('{is_dm: 1'b0, chk: 1'b1, data: data});
    @(negedge clk);
    e = exp_q.pop_front();
    total++; if ({bus.if_valid, bus.dm_valid} !== (e.is_dm ? 2'b01 : 2'b10)) begin bad++; $display("[TB] FAIL %s_c2_valid: got if/dm=%b%b want dm=%b", name, bus.if_valid, bus.dm_valid, e.is_dm); end
    if (e.chk) begin
      total++; if (bus.if_rdata !== e.data) begin bad++; $display("[TB] FAIL %s_c2_rdata: got %h want %h", name, bus.if_rdata, e.data); end
    end
    total++; if ({bus.mem_req, bus.PCwrite} !== 2'b01) begin bad++; $display("[TB] FAIL %s_c2_req_pcw: got %b%b want 01", name, bus.mem_req, bus.PCwrite); end
    cyc();
    bus.if_req     = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    @(negedge clk);
    total++; if ({bus.if_valid, bus.mem_req} !== 2'b00) begin bad++; $display("[TB] FAIL %s_c3_idle: got %b%b want 00", name, bus.if_valid, bus.mem_req); end
  endtask

  task automatic test_lone_fetch();
    run_fetch(32'h0000_0100, 32'h0050_0093, "lone");
  endtask

  task automatic test_priority();
    cyc();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0300;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h0000_2000;
    @(negedge clk);
    total++; if ({bus.mem_stall, bus.PCwrite} !== 2'b10) begin bad++; $display("[TB] FAIL prio_c0_stall: got %b%b want 10", bus.mem_stall, bus.PCwrite); end
    cyc();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_addr !== 32'h0000_2000 || bus.mem_req !== 1'b1) begin bad++; $display("[TB] FAIL prio_c1_grant: got req=%b addr=%h want 1 00002000", bus.mem_req, bus.mem_addr); end
    total++; if (bus.mem_stall !== 1'b1) begin bad++; $display("[TB] FAIL prio_c1_stall: got %b want 1", bus.mem_stall); end
    cyc();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1122_3344;
    exp_q.push_back('{is_dm: 1'b1, chk: 1'b1, data: 32'h1122_3344});
    @(negedge clk);
    e = exp_q.pop_front();
    total++; if ({bus.if_valid, bus.dm_valid} !== (e.is_dm ? 2'b01 : 2'b10)) begin bad++; $display("[TB] FAIL prio_dm_valid: got if/dm=%b%b want dm=%b", bus.if_valid, bus.dm_valid, e.is_dm); end
    if (e.chk) begin
      total++; if (bus.dm_rdata !== e.data) begin bad++; $display("[TB] FAIL prio_dm_rdata: got %h want %h", bus.dm_rdata, e.data); end
    end
    total++; if ({bus.mem_stall, bus.PCwrite} !== 2'b00) begin bad++; $display("[TB] FAIL prio_c2_stall: got %b%b want 00", bus.mem_stall, bus.PCwrite); end
    cyc();
    bus.dm_req     = 1'b0;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("[TB] FAIL prio_c3_req: got %b want 0", bus.mem_req); end
    cyc();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0300) begin bad++; $display("[TB] FAIL prio_c4_fetch: got req=%b addr=%h want 1 00000300", bus.mem_req, bus.mem_addr); end
    cyc();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hAABB_CCDD;
    exp_q.push_back('{is_dm: 1'b0, chk: 1'b1, data: 32'hAABB_CCDD});
    @(negedge clk);
    e = exp_q.pop_front();
    total++; if ({bus.if_valid, bus.dm_valid} !== (e.is_dm ? 2'b01 : 2'b10)) begin bad++; $display("[TB] FAIL prio_if_valid: got if/dm=%b%b want dm=%b", bus.if_valid, bus.dm_valid, e.is_dm); end
    if (e.chk) begin
      total++; if (bus.if_rdata !== e.data) begin bad++; $display("[TB] FAIL prio_if_rdata: got %h want %h", bus.if_rdata, e.data); end
    end
    total++; if (bus.PCwrite !== 1'b1) begin bad++; $display("[TB] FAIL prio_c5_pcw: got %b want 1", bus.PCwrite); end
    cyc();
    bus.if_req     = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_store_backpressure();
    cyc();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h0000_0044;
    bus.dm_wdata = 32'hDEAD_BEEF;
    bus.dm_be    = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      cyc();
      bus.mem_ready = (k == 3);
      @(negedge clk);
      total++;
      if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b11_0011 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_addr !== 32'h0000_0044) begin
        bad++;
        $display("[TB] FAIL store_hold_%0d: got req=%b we=%b be=%b wd=%h a=%h want 1 1 0011 deadbeef 00000044",
                 k, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr);
      end
      total++; if (bus.dm_valid !== 1'b0) begin bad++; $display("[TB] FAIL store_early_valid_%0d: got %b want 0", k, bus.dm_valid); end
    end
    cyc();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    exp_q.push_back('{is_dm: 1'b1, chk: 1'b0, data: 32'h0});
    @(negedge clk);
    e = exp_q.pop_front();
    total++; if ({bus.if_valid, bus.dm_valid} !== (e.is_dm ? 2'b01 : 2'b10)) begin bad++; $display("[TB] FAIL store_ack: got if/dm=%b%b want dm=%b", bus.if_valid, bus.dm_valid, e.is_dm); end
    if (e.chk) begin
      total++; if (bus.dm_rdata !== e.data) begin bad++; $display("[TB] FAIL store_rdata: got %h want %h", bus.dm_rdata, e.data); end
    end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("[TB] FAIL store_req_after: got %b want 0", bus.mem_req); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_timeout();
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    cyc();
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h0000_0080;
    exp_q.push_back('{is_dm: 1'b1, chk: 1'b1, data: 32'h0});
    @(negedge clk);
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL tmo_pre_err: got %b want 0", bus.timeout_err); end
    for (int k = 1; k <= 20 && !found; k++) begin
      cyc();
      @(negedge clk);
      if (bus.dm_valid === 1'b1) begin
        found = 1'b1;
        n = k;
      end else begin
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("[TB] FAIL tmo_wait_req_%0d: got %b want 1", k, bus.mem_req); end
      end
    end
    total++; if (n != MW + 1) begin bad++; $display("[TB] FAIL tmo_cycle: got %0d want %0d", n, MW + 1); end
    if (found) begin
      e = exp_q.pop_front();
      total++; if ({bus.if_valid, bus.dm_valid} !== (e.is_dm ? 2'b01 : 2'b10)) begin bad++; $display("[TB] FAIL tmo_valid: got if/dm=%b%b want dm=%b", bus.if_valid, bus.dm_valid, e.is_dm); end
      total++; if (bus.dm_rdata !== e.data) begin bad++; $display("[TB] FAIL tmo_rdata: got %h want %h", bus.dm_rdata, e.data); end
    end else begin
      void'(exp_q.pop_front());
    end
    cyc();
    bus.dm_req = 1'b0;
    @(negedge clk);
    total++; if ({bus.timeout_err, bus.mem_req, bus.dm_valid} !== 3'b100) begin bad++; $display("[TB] FAIL tmo_after: got err/req/valid=%b%b%b want 100", bus.timeout_err, bus.mem_req, bus.dm_valid); end
    run_fetch(32'h0000_0104, 32'h00A0_0113, "post_tmo");
    total++; if (bus.timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL tmo_sticky: got %b want 1", bus.timeout_err); end
  endtask

  task automatic test_reset_mid_op();
    cyc();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0500;
    cyc();
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.if_req = 1'b0;
    #1;
    total++; if ({bus.mem_req, bus.if_valid, bus.dm_valid} !== 3'b000) begin bad++; $display("[TB] FAIL rmo_in_reset: got req/if/dm=%b%b%b want 000", bus.mem_req, bus.if_valid, bus.dm_valid); end
    total++; if ({bus.timeout_err, bus.PCwrite} !== 2'b01) begin bad++; $display("[TB] FAIL rmo_err_pcw: got %b%b want 01", bus.timeout_err, bus.PCwrite); end
    cyc();
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rmo_release_req: got %b want 0", bus.mem_req); end
    cyc();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    total++; if ({bus.if_valid, bus.dm_valid} !== 2'b00) begin bad++; $display("[TB] FAIL rmo_stray_rvalid: got %b%b want 00", bus.if_valid, bus.dm_valid); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_spurious_rvalid();
    for (int k = 0; k < 3; k++) begin
      cyc();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
      @(negedge clk);
      total++; if ({bus.if_valid, bus.dm_valid, bus.mem_req} !== 3'b000) begin bad++; $display("[TB] FAIL spur_valid_%0d: got if/dm/req=%b%b%b want 000", k, bus.if_valid, bus.dm_valid, bus.mem_req); end
      total++; if ({bus.PCwrite, bus.mem_stall} !== 2'b10) begin bad++; $display("[TB] FAIL spur_stall_%0d: got %b%b want 10", k, bus.PCwrite, bus.mem_stall); end
    end
    cyc();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_priority();
    test_store_backpressure();
    test_timeout();
    test_reset_mid_op();
    test_spurious_rvalid();
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
